// File: rtl/mac_pkg.sv
// Shared helpers for the multi-bank MAC: width math, accumulator limits
// and parameter legality.
package mac_pkg;

   localparam int MAX_W = 128;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic logic [MAX_W-1:0] acc_max(input int w);
      return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
   endfunction

   function automatic logic [MAX_W-1:0] acc_min(input int w);
      return MAX_W'(1) << (w - 1);
   endfunction

   function automatic bit params_ok(
      input int dw,
      input int aw,
      input int nb,
      input int ow
   );
      return (aw >= 2 * dw + 1) && (ow > 0) && (aw % ow == 0) &&
             (nb >= 2) && ((nb & (nb - 1)) == 0) && (aw <= MAX_W - 1);
   endfunction

endpackage

// File: rtl/mac_multibank_if.sv
// Operand-pair channel into the MAC core; valid/ready handshake.
interface mac_multibank_if #(
   parameter int DATA_W = 8,
   parameter int BANK_W = 2
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic [BANK_W-1:0] in_bank;
   logic              in_signed;
   logic              in_sub;

   modport master (
      output in_valid, in_a, in_b, in_bank, in_signed, in_sub,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_a, in_b, in_bank, in_signed, in_sub,
      output in_ready
   );
endinterface

// File: rtl/mac_sat_acc.sv
// One-bit-wide-guard add/sub of an extended product onto an accumulator,
// with saturate-or-wrap and overflow detect.
module mac_sat_acc
   import mac_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24
) (
   input  logic [ACC_W-1:0]    acc,
   input  logic [2*DATA_W-1:0] prod,
   input  logic                is_signed,
   input  logic                sub,
   input  logic                sat,
   output logic [ACC_W-1:0]    res,
   output logic                ovf
);
   localparam int PW = 2 * DATA_W;
   localparam int XW = ACC_W + 1;
   localparam logic [ACC_W-1:0] LIM_HI = ACC_W'(acc_max(ACC_W));
   localparam logic [ACC_W-1:0] LIM_LO = ACC_W'(acc_min(ACC_W));

   logic [XW-1:0] ext;
   logic [XW-1:0] accx;
   logic [XW-1:0] sum;
   logic          neg;

   always_comb begin
      ext  = {{(XW - PW){is_signed & prod[PW-1]}}, prod};
      accx = {acc[ACC_W-1], acc};
      sum  = sub ? (accx - ext) : (accx + ext);
      // guard bit disagreeing with the sign bit means out of range
      ovf  = sum[XW-1] ^ sum[XW-2];
      neg  = sum[XW-1];
      res  = sum[ACC_W-1:0];
      unique case (1'b1)
         (!ovf || !sat):      res = sum[ACC_W-1:0];
         (ovf && sat && neg): res = LIM_LO;
         (ovf && sat && !neg): res = LIM_HI;
      endcase
   end
endmodule

// File: rtl/mac_multibank.sv
// Multi-bank MAC core: S1 operand register, S2 product register, then
// accumulate into the addressed bank; sliced registered readout.
module mac_multibank
   import mac_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ACC_W     = 24,
   parameter int NUM_BANKS = 4,
   parameter int OUT_W     = 8,
   localparam int BANK_W   = clog2(NUM_BANKS),
   localparam int NSLICE   = ACC_W / OUT_W,
   localparam int SEL_W    = clog2(NSLICE)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mac_multibank_if.slave       in_ch,
   input  logic                 cfg_sat,
   input  logic                 clr_valid,
   input  logic [BANK_W-1:0]    clr_bank,
   input  logic [BANK_W-1:0]    rd_bank,
   input  logic [SEL_W-1:0]     rd_sel,
   output logic [OUT_W-1:0]     rd_data,
   output logic [NUM_BANKS-1:0] ovf,
   output logic                 busy
);
   localparam int PW = 2 * DATA_W;

   if (!params_ok(DATA_W, ACC_W, NUM_BANKS, OUT_W)) begin : g_bad_params
      $error("mac_multibank: illegal parameter combination");
   end

   typedef struct packed {
      logic              v;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [BANK_W-1:0] bank;
      logic              sgn;
      logic              sub;
   } s1_t;

   typedef struct packed {
      logic              v;
      logic [PW-1:0]     prod;
      logic [BANK_W-1:0] bank;
      logic              sgn;
      logic              sub;
   } s2_t;

   s1_t              s1;
   s2_t              s2;
   logic             accept;
   logic [PW-1:0]    prod_n;
   logic [ACC_W-1:0] acc [NUM_BANKS];
   logic [ACC_W-1:0] acc_cur;
   logic [ACC_W-1:0] acc_res;
   logic             acc_ovf;
   logic [ACC_W-1:0] rd_word;
   logic [OUT_W-1:0] rd_next;

   assign in_ch.in_ready = rst_n & ~clr_valid;
   assign accept = in_ch.in_valid & in_ch.in_ready;
   assign busy = s1.v | s2.v;

   always_comb begin
      if (s1.sgn)
         prod_n = {{DATA_W{s1.a[DATA_W-1]}}, s1.a} *
                  {{DATA_W{s1.b[DATA_W-1]}}, s1.b};
      else
         prod_n = {{DATA_W{1'b0}}, s1.a} * {{DATA_W{1'b0}}, s1.b};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1.v    <= accept;
         s1.a    <= in_ch.in_a;
         s1.b    <= in_ch.in_b;
         s1.bank <= in_ch.in_bank;
         s1.sgn  <= in_ch.in_signed;
         s1.sub  <= in_ch.in_sub;
         s2.v    <= s1.v;
         s2.prod <= prod_n;
         s2.bank <= s1.bank;
         s2.sgn  <= s1.sgn;
         s2.sub  <= s1.sub;
      end
   end

   assign acc_cur = acc[s2.bank];

   mac_sat_acc #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_sat_acc (
      .acc       (acc_cur),
      .prod      (s2.prod),
      .is_signed (s2.sgn),
      .sub       (s2.sub),
      .sat       (cfg_sat),
      .res       (acc_res),
      .ovf       (acc_ovf)
   );

   always_comb begin
      rd_word = acc[rd_bank];
      rd_next = '0;
      for (int i = 0; i < NSLICE; i++)
         if (rd_sel == SEL_W'(i)) rd_next = rd_word[i*OUT_W +: OUT_W];
   end

   // a clear wins over an S2 write to the same bank at the same edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_BANKS; b++) acc[b] <= '0;
         ovf     <= '0;
         rd_data <= '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (clr_valid && clr_bank == BANK_W'(b)) begin
               acc[b] <= '0;
               ovf[b] <= 1'b0;
            end else if (s2.v && s2.bank == BANK_W'(b)) begin
               acc[b] <= acc_res;
               if (acc_ovf) ovf[b] <= 1'b1;
            end
         end
         rd_data <= rd_next;
      end
   end
endmodule

// File: tb/tb_mac_multibank.sv
// Directed self-checking bench for mac_multibank.
module tb_mac_multibank;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_sat = 1'b0;
   logic       clr_valid = 1'b0;
   logic [1:0] clr_bank = '0;
   logic [1:0] rd_bank = '0;
   logic [1:0] rd_sel = '0;
   logic [7:0] rd_data;
   logic [3:0] ovf;
   logic       busy;
   int         n_checks = 0;
   int         n_fail = 0;

   mac_multibank_if #(.DATA_W(8), .BANK_W(2)) in_if ();

   mac_multibank #(
      .DATA_W    (8),
      .ACC_W     (24),
      .NUM_BANKS (4),
      .OUT_W     (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_ch     (in_if),
      .cfg_sat   (cfg_sat),
      .clr_valid (clr_valid),
      .clr_bank  (clr_bank),
      .rd_bank   (rd_bank),
      .rd_sel    (rd_sel),
      .rd_data   (rd_data),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] bank, input logic sgn,
                        input logic sub);
      in_if.in_valid  = 1'b1;
      in_if.in_a      = a;
      in_if.in_b      = b;
      in_if.in_bank   = bank;
      in_if.in_signed = sgn;
      in_if.in_sub    = sub;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] bank, input logic sgn,
                       input logic sub);
      drive(a, b, bank, sgn, sub);
      tick();
      in_if.in_valid = 1'b0;
   endtask

   task automatic clear(input logic [1:0] bank);
      clr_valid = 1'b1;
      clr_bank  = bank;
      tick();
      clr_valid = 1'b0;
   endtask

   task automatic read_acc(input logic [1:0] bank, output logic [23:0] v);
      rd_bank = bank;
      v = '0;
      for (int s = 0; s < 3; s++) begin
         rd_sel = 2'(s);
         tick();
         v[s*8 +: 8] = rd_data;
      end
   endtask

   task automatic test_reset();
      logic [23:0] v;
      rst_n = 1'b0;
      tick(2);
      n_checks++;
      if (in_if.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b expected 0", in_if.in_ready);
      end
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      n_checks++;
      if (ovf !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_ovf: got %h expected 0", ovf);
      end
      n_checks++;
      if (rd_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_rd_data: got %h expected 00", rd_data);
      end
      n_checks++;
      if (in_if.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready_after: got %b expected 1", in_if.in_ready);
      end
      for (int b = 0; b < 4; b++) begin
         read_acc(2'(b), v);
         n_checks++;
         if (v !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_acc%0d: got %h expected 000000", b, v);
         end
      end
   endtask

   task automatic test_signed_add();
      logic [7:0] exp_sl [4];
      exp_sl = '{8'hF4, 8'h3F, 8'h00, 8'h00};
      send(8'd3, 8'hFC, 2'd0, 1'b1, 1'b0);
      send(8'h80, 8'h80, 2'd0, 1'b1, 1'b0);
      tick(2);
      rd_bank = 2'd0;
      for (int s = 0; s < 4; s++) begin
         rd_sel = 2'(s);
         tick();
         n_checks++;
         if (rd_data !== exp_sl[s]) begin
            n_fail++;
            $display("FAIL signed_add_slice%0d: got %h expected %h",
                     s, rd_data, exp_sl[s]);
         end
      end
      n_checks++;
      if (ovf !== 4'h0) begin
         n_fail++;
         $display("FAIL signed_add_ovf: got %h expected 0", ovf);
      end
   endtask

   task automatic test_signedness();
      logic [23:0] v;
      logic [23:0] exp_acc [4];
      exp_acc = '{24'h000000, 24'h00FE01, 24'hFFFFFB, 24'h000000};
      clear(2'd0);
      send(8'hFF, 8'hFF, 2'd1, 1'b0, 1'b0);
      send(8'hFF, 8'hFF, 2'd2, 1'b1, 1'b0);
      send(8'h02, 8'h03, 2'd2, 1'b1, 1'b1);
      tick(2);
      for (int b = 0; b < 4; b++) begin
         read_acc(2'(b), v);
         n_checks++;
         if (v !== exp_acc[b]) begin
            n_fail++;
            $display("FAIL signedness_acc%0d: got %h expected %h",
                     b, v, exp_acc[b]);
         end
      end
      n_checks++;
      if (ovf !== 4'h0) begin
         n_fail++;
         $display("FAIL signedness_ovf: got %h expected 0", ovf);
      end
   endtask

   task automatic test_saturation();
      logic [23:0] v;
      clear(2'd2);
      cfg_sat = 1'b1;
      drive(8'h80, 8'h80, 2'd2, 1'b1, 1'b0);
      tick(512);
      in_if.in_valid = 1'b0;
      tick(2);
      read_acc(2'd2, v);
      n_checks++;
      if (v !== 24'h7FFFFF) begin
         n_fail++;
         $display("FAIL sat_clamp: got %h expected 7fffff", v);
      end
      n_checks++;
      if (ovf !== 4'b0100) begin
         n_fail++;
         $display("FAIL sat_ovf: got %b expected 0100", ovf);
      end
      clear(2'd2);
      cfg_sat = 1'b0;
      drive(8'h80, 8'h80, 2'd2, 1'b1, 1'b0);
      tick(512);
      in_if.in_valid = 1'b0;
      tick(2);
      read_acc(2'd2, v);
      n_checks++;
      if (v !== 24'h800000) begin
         n_fail++;
         $display("FAIL wrap_value: got %h expected 800000", v);
      end
      n_checks++;
      if (ovf !== 4'b0100) begin
         n_fail++;
         $display("FAIL wrap_ovf: got %b expected 0100", ovf);
      end
      clear(2'd2);
      read_acc(2'd2, v);
      n_checks++;
      if (v !== 24'h0) begin
         n_fail++;
         $display("FAIL clear_value: got %h expected 000000", v);
      end
      n_checks++;
      if (ovf !== 4'b0000) begin
         n_fail++;
         $display("FAIL clear_ovf: got %b expected 0000", ovf);
      end
   endtask

   task automatic test_clear_hazard();
      logic [23:0] v;
      drive(8'd10, 8'd10, 2'd3, 1'b0, 1'b0);
      tick();
      drive(8'd1, 8'd1, 2'd3, 1'b0, 1'b0);
      tick();
      in_if.in_valid = 1'b0;
      clr_valid = 1'b1;
      clr_bank  = 2'd3;
      #1;
      n_checks++;
      if (in_if.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL hazard_ready: got %b expected 0", in_if.in_ready);
      end
      tick();
      clr_valid = 1'b0;
      tick();
      read_acc(2'd3, v);
      n_checks++;
      if (v !== 24'h000001) begin
         n_fail++;
         $display("FAIL hazard_acc3: got %h expected 000001", v);
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] v;
      clear(2'd1);
      rd_bank = 2'd1;
      rd_sel  = 2'd0;
      for (int i = 1; i <= 16; i++) begin
         drive(8'(i), 8'd1, 2'd1, 1'b0, 1'b0);
         tick();
      end
      in_if.in_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_busy_l0: got %b expected 1", busy);
      end
      tick();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_busy_l1: got %b expected 1", busy);
      end
      tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_busy_l2: got %b expected 0", busy);
      end
      n_checks++;
      if (rd_data !== 8'd120) begin
         n_fail++;
         $display("FAIL b2b_pre_update: got %0d expected 120", rd_data);
      end
      tick();
      n_checks++;
      if (rd_data !== 8'd136) begin
         n_fail++;
         $display("FAIL b2b_l3: got %0d expected 136", rd_data);
      end
      read_acc(2'd1, v);
      n_checks++;
      if (v !== 24'd136) begin
         n_fail++;
         $display("FAIL b2b_acc1: got %h expected 000088", v);
      end
   endtask

   task automatic test_reset_mid();
      logic [23:0] v;
      drive(8'd5, 8'd5, 2'd0, 1'b0, 1'b0);
      tick(3);
      rst_n = 1'b0;
      tick();
      in_if.in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_busy: got %b expected 0", busy);
      end
      n_checks++;
      if (ovf !== 4'h0) begin
         n_fail++;
         $display("FAIL rst_mid_ovf: got %h expected 0", ovf);
      end
      n_checks++;
      if (rd_data !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_mid_rd_data: got %h expected 00", rd_data);
      end
      for (int b = 0; b < 4; b++) begin
         read_acc(2'(b), v);
         n_checks++;
         if (v !== 24'h0) begin
            n_fail++;
            $display("FAIL rst_mid_acc%0d: got %h expected 000000", b, v);
         end
      end
      send(8'd2, 8'd2, 2'd0, 1'b0, 1'b0);
      tick(2);
      read_acc(2'd0, v);
      n_checks++;
      if (v !== 24'd4) begin
         n_fail++;
         $display("FAIL rst_mid_first: got %h expected 000004", v);
      end
   endtask

   initial begin
      in_if.in_valid  = 1'b0;
      in_if.in_a      = '0;
      in_if.in_b      = '0;
      in_if.in_bank   = '0;
      in_if.in_signed = 1'b0;
      in_if.in_sub    = 1'b0;
      test_reset();
      test_signed_add();
      test_signedness();
      test_saturation();
      test_clear_hazard();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
